// File: rtl/cpu_ad48_lsu_mc.sv
// Multi-cycle load/store unit for the ad48 core: effective-address generation with
// offset/pre/post-modify, a req/gnt/rvalid memory port, and D/A register writebacks.
module cpu_ad48_lsu_mc #(
    parameter int DATA_W  = 48,
    parameter int DISP_W  = 33,
    parameter int ADDR_W  = 7,
    parameter int DEPTH   = 128,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              issue_store,
    input  logic [1:0]        issue_mode,
    input  logic [DATA_W-1:0] issue_base,
    input  logic [DISP_W-1:0] issue_disp,
    input  logic [DATA_W-1:0] issue_sdata,
    input  logic [2:0]        issue_dreg,
    input  logic [2:0]        issue_areg,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              d_we,
    output logic [2:0]        d_waddr,
    output logic [DATA_W-1:0] d_wdata,
    output logic              a_we,
    output logic [2:0]        a_waddr,
    output logic [DATA_W-1:0] a_wdata,

    output logic              done,
    output logic              fault
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_next;

    logic              op_store;
    logic              op_modify;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_na;
    logic [DATA_W-1:0] op_sdata;
    logic [2:0]        op_dreg;
    logic [2:0]        op_areg;
    logic              op_fault;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  tmo_cnt;

    logic              accept;
    logic              abort;
    logic              tmo_hit;
    logic [DATA_W-1:0] disp_ext;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] ea;
    logic              acc_fault;

    // Address arithmetic is done on the raw issue fields so the fault decision is known at accept.
    assign disp_ext  = {{(DATA_W - DISP_W){issue_disp[DISP_W-1]}}, issue_disp};
    assign sum       = issue_base + disp_ext;
    assign ea        = (issue_mode == 2'b10) ? issue_base : sum;
    assign acc_fault = (issue_mode == 2'b11) || (ea >= DATA_W'(DEPTH));
    assign accept    = issue_valid && (state == S_IDLE);
    assign tmo_hit   = (TIMEOUT != 0) && (int'(tmo_cnt) == TIMEOUT - 1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        abort       = 1'b0;
        issue_ready = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        d_we        = 1'b0;
        d_waddr     = '0;
        d_wdata     = '0;
        a_we        = 1'b0;
        a_waddr     = '0;
        a_wdata     = '0;
        done        = 1'b0;
        fault       = 1'b0;
        case (state)
            S_IDLE: begin
                issue_ready = 1'b1;
                if (accept) begin
                    state_next = acc_fault ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                mem_req   = 1'b1;
                mem_we    = op_store;
                mem_addr  = op_addr;
                mem_wdata = op_store ? op_sdata : '0;
                if (mem_gnt) begin
                    state_next = op_store ? S_DONE : S_RESP;
                end else if (tmo_hit) begin
                    abort      = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_RESP: begin
                if (mem_rvalid) begin
                    state_next = S_DONE;
                end else if (tmo_hit) begin
                    abort      = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                fault      = op_fault;
                state_next = S_IDLE;
                if (!op_fault && !op_store) begin
                    d_we    = 1'b1;
                    d_waddr = op_dreg;
                    d_wdata = rdata_q;
                end
                // A0 is hard-wired, so a modify targeting it is silently dropped.
                if (!op_fault && op_modify && (op_areg != 3'd0)) begin
                    a_we    = 1'b1;
                    a_waddr = op_areg;
                    a_wdata = op_na;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_store  <= 1'b0;
            op_modify <= 1'b0;
            op_addr   <= '0;
            op_na     <= '0;
            op_sdata  <= '0;
            op_dreg   <= '0;
            op_areg   <= '0;
            op_fault  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                op_store  <= issue_store;
                op_modify <= (issue_mode == 2'b01) || (issue_mode == 2'b10);
                op_addr   <= ea[ADDR_W-1:0];
                op_na     <= sum;
                op_sdata  <= issue_sdata;
                op_dreg   <= issue_dreg;
                op_areg   <= issue_areg;
                op_fault  <= acc_fault;
            end else if (abort) begin
                op_fault <= 1'b1;
            end
            if ((state == S_RESP) && mem_rvalid) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    // Wait counter restarts on every state change, so it measures time spent in the current wait.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else if (state_next != state) begin
            tmo_cnt <= '0;
        end else if ((state == S_REQ) || (state == S_RESP)) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_ad48_lsu_mc.sv
// Directed bench for cpu_ad48_lsu_mc: addressing modes, variable memory latency,
// A0 suppression, accept-time faults, timeout abort and mid-operation reset.
module tb_cpu_ad48_lsu_mc;

    logic        clk;
    logic        resetn;
    logic        issue_valid;
    logic        issue_ready;
    logic        issue_store;
    logic [1:0]  issue_mode;
    logic [47:0] issue_base;
    logic [32:0] issue_disp;
    logic [47:0] issue_sdata;
    logic [2:0]  issue_dreg;
    logic [2:0]  issue_areg;
    logic        mem_req;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [47:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [47:0] mem_rdata;
    logic        d_we;
    logic [2:0]  d_waddr;
    logic [47:0] d_wdata;
    logic        a_we;
    logic [2:0]  a_waddr;
    logic [47:0] a_wdata;
    logic        done;
    logic        fault;

    int compared;
    int mismatched;
    int doneCount;
    int aweCount;
    int reqCount;

    cpu_ad48_lsu_mc #(
        .DATA_W(48), .DISP_W(33), .ADDR_W(7), .DEPTH(128), .TIMEOUT(8)
    ) dut (
        .clk(clk), .resetn(resetn),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_store(issue_store),
        .issue_mode(issue_mode), .issue_base(issue_base), .issue_disp(issue_disp),
        .issue_sdata(issue_sdata), .issue_dreg(issue_dreg), .issue_areg(issue_areg),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .d_we(d_we), .d_waddr(d_waddr), .d_wdata(d_wdata),
        .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .done(done), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sample the pre-edge values; the stimulus block clears them at negedges.
    always @(posedge clk) begin
        if (done)    doneCount <= doneCount + 1;
        if (a_we)    aweCount  <= aweCount + 1;
        if (mem_req) reqCount  <= reqCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic isStore, input logic [1:0] mode, input logic [47:0] base,
                                 input logic [32:0] disp, input logic [47:0] sdata,
                                 input logic [2:0] dreg, input logic [2:0] areg);
        doneCount   = 0;
        aweCount    = 0;
        reqCount    = 0;
        issue_valid = 1'b1;
        issue_store = isStore;
        issue_mode  = mode;
        issue_base  = base;
        issue_disp  = disp;
        issue_sdata = sdata;
        issue_dreg  = dreg;
        issue_areg  = areg;
        @(negedge clk);
        issue_valid = 1'b0;
    endtask

    initial begin
        compared = 0; mismatched = 0;
        doneCount = 0; aweCount = 0; reqCount = 0;
        resetn = 1'b0; issue_valid = 1'b0; issue_store = 1'b0; issue_mode = 2'b00;
        issue_base = '0; issue_disp = '0; issue_sdata = '0; issue_dreg = '0; issue_areg = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_ready", issue_ready, 1);
        checkOutput("rst_req", mem_req, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_fault", fault, 0);
        checkOutput("rst_dwe", d_we, 0);
        checkOutput("rst_awe", a_we, 0);
        resetn = 1'b1;
        @(negedge clk);

        $display("[TB] offset load, rvalid 3 cycles after gnt");
        applyStimulus(1'b0, 2'b00, 48'd2, 33'd0, 48'd0, 3'd2, 3'd3);
        checkOutput("t1_req", mem_req, 1);
        checkOutput("t1_we", mem_we, 0);
        checkOutput("t1_addr", mem_addr, 2);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        checkOutput("t1_req_drop", mem_req, 0);
        repeat (2) @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 48'd300;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
        checkOutput("t1_done", done, 1);
        checkOutput("t1_dwe", d_we, 1);
        checkOutput("t1_dwaddr", d_waddr, 2);
        checkOutput("t1_dwdata", d_wdata, 300);
        checkOutput("t1_awe", a_we, 0);
        @(negedge clk);
        checkOutput("t1_done_cnt", doneCount, 1);
        checkOutput("t1_ready", issue_ready, 1);

        $display("[TB] pre-modify load, minimum latency");
        applyStimulus(1'b0, 2'b01, 48'd2, 33'd2, 48'd0, 3'd3, 3'd1);
        checkOutput("t2_addr", mem_addr, 4);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 48'd500;
        @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = '0;
        checkOutput("t2_done_at3", done, 1);
        checkOutput("t2_dwaddr", d_waddr, 3);
        checkOutput("t2_dwdata", d_wdata, 500);
        checkOutput("t2_awe", a_we, 1);
        checkOutput("t2_awaddr", a_waddr, 1);
        checkOutput("t2_awdata", a_wdata, 4);
        @(negedge clk);

        $display("[TB] post-modify store, gnt withheld 2 cycles");
        applyStimulus(1'b1, 2'b10, 48'd5, 33'd3, 48'd67890, 3'd0, 3'd2);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("t3_req_%0d", i), mem_req, 1);
            checkOutput($sformatf("t3_we_%0d", i), mem_we, 1);
            checkOutput($sformatf("t3_addr_%0d", i), mem_addr, 5);
            checkOutput($sformatf("t3_wdata_%0d", i), mem_wdata, 67890);
            if (i == 2) mem_gnt = 1'b1;
            @(negedge clk);
        end
        mem_gnt = 1'b0;
        checkOutput("t3_done", done, 1);
        checkOutput("t3_dwe", d_we, 0);
        checkOutput("t3_awe", a_we, 1);
        checkOutput("t3_awaddr", a_waddr, 2);
        checkOutput("t3_awdata", a_wdata, 8);
        @(negedge clk);

        $display("[TB] pre-modify store to A0, immediate gnt");
        applyStimulus(1'b1, 2'b01, 48'd0, 33'd2, 48'd11, 3'd0, 3'd0);
        checkOutput("t4_addr", mem_addr, 2);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        checkOutput("t4_done_at2", done, 1);
        checkOutput("t4_fault", fault, 0);
        @(negedge clk);
        checkOutput("t4_awe_cnt", aweCount, 0);

        $display("[TB] accept-time faults");
        applyStimulus(1'b0, 2'b00, 48'd0, 33'h1_FFFF_FFFF, 48'd0, 3'd1, 3'd1);
        checkOutput("t5a_done", done, 1);
        checkOutput("t5a_fault", fault, 1);
        checkOutput("t5a_dwe", d_we, 0);
        @(negedge clk);
        checkOutput("t5a_req_cnt", reqCount, 0);
        applyStimulus(1'b0, 2'b11, 48'd1, 33'd0, 48'd0, 3'd1, 3'd1);
        checkOutput("t5b_fault", fault, 1);
        checkOutput("t5b_awe", a_we, 0);
        @(negedge clk);
        checkOutput("t5b_req_cnt", reqCount, 0);
        applyStimulus(1'b1, 2'b00, 48'd128, 33'd0, 48'd0, 3'd1, 3'd1);
        checkOutput("t5c_fault", fault, 1);
        @(negedge clk);
        applyStimulus(1'b1, 2'b00, 48'd127, 33'd0, 48'd0, 3'd1, 3'd1);
        checkOutput("t5d_req", mem_req, 1);
        checkOutput("t5d_addr", mem_addr, 127);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        checkOutput("t5d_fault", fault, 0);
        @(negedge clk);

        $display("[TB] timeout with gnt never asserted");
        applyStimulus(1'b1, 2'b01, 48'd10, 33'd1, 48'd7, 3'd0, 3'd4);
        repeat (7) @(negedge clk);
        checkOutput("t6_req_last", mem_req, 1);
        @(negedge clk);
        checkOutput("t6_done", done, 1);
        checkOutput("t6_fault", fault, 1);
        checkOutput("t6_req_off", mem_req, 0);
        checkOutput("t6_awe", a_we, 0);
        @(negedge clk);
        checkOutput("t6_req_cnt", reqCount, 8);

        $display("[TB] reset during REQ and during RESP");
        applyStimulus(1'b1, 2'b00, 48'd3, 33'd0, 48'd9, 3'd0, 3'd0);
        checkOutput("t7_req", mem_req, 1);
        resetn = 1'b0;
        #1;
        checkOutput("t7_req_drop", mem_req, 0);
        checkOutput("t7_ready", issue_ready, 1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 2'b00, 48'd6, 33'd0, 48'd0, 3'd5, 3'd0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        resetn = 1'b0;
        #1;
        checkOutput("t8_req", mem_req, 0);
        checkOutput("t8_ready", issue_ready, 1);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("t8_no_done", doneCount, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
